serial_code_rx: RTL and testbench

- Serial front end for the 7-segment display decoder stage.
- Receives one frame on a single-wire line: start bit, 5 code bits (b1 first), 1 parity bit, stop bit.
- Holds the last good frame stable on b1..b5/b_par, which feed the decoder's parity check and segment logic.
- Does not check parity itself; b_par is passed through raw so the downstream stage remains the only parity authority.

---
 rtl/serial_code_rx.sv | 148 ++++++++++++++
 tb/tb_serial_code_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_code_rx.sv
// Single-wire frame receiver (start, 5 code bits, parity, stop) that holds the
// last good code stable for the 7-segment decoder. Parity is passed through unchecked.
module serial_code_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic b1,
    output logic b2,
    output logic b3,
    output logic b4,
    output logic b5,
    output logic b_par,
    output logic frame_valid,
    output logic frame_err,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'd4;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [4:0]       shadow, shadow_n;
    logic             shadow_par, shadow_par_n;
    logic [4:0]       code, code_n;
    logic             par_n, valid_n, err_n, busy_n;
    logic             rx_meta, rx_s, rx_s_d;

    // Synchronizer and edge register preset to idle-high so reset never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shadow      <= '0;
            shadow_par  <= 1'b0;
            code        <= '0;
            b_par       <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            clk_cnt     <= clk_cnt_n;
            bit_cnt     <= bit_cnt_n;
            shadow      <= shadow_n;
            shadow_par  <= shadow_par_n;
            code        <= code_n;
            b_par       <= par_n;
            frame_valid <= valid_n;
            frame_err   <= err_n;
            busy        <= busy_n;
        end
    end

    always_comb begin
        state_n      = state;
        clk_cnt_n    = clk_cnt;
        bit_cnt_n    = bit_cnt;
        shadow_n     = shadow;
        shadow_par_n = shadow_par;
        code_n       = code;
        par_n        = b_par;
        valid_n      = 1'b0;
        err_n        = 1'b0;

        case (state)
            IDLE: begin
                clk_cnt_n = '0;
                bit_cnt_n = '0;
                if (rx_s_d && !rx_s) state_n = START;
            end
            START: begin
                if (clk_cnt == HALF_M1) begin
                    clk_cnt_n = '0;
                    bit_cnt_n = '0;
                    state_n   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (clk_cnt == FULL_M1) begin
                    clk_cnt_n         = '0;
                    shadow_n[bit_cnt] = rx_s;
                    if (bit_cnt == LAST_BIT) state_n = PARITY;
                    else bit_cnt_n = bit_cnt + 3'd1;
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            PARITY: begin
                if (clk_cnt == FULL_M1) begin
                    clk_cnt_n    = '0;
                    shadow_par_n = rx_s;
                    state_n      = STOP;
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                // Leaving mid-stop-bit lets a back-to-back start edge be caught
                if (clk_cnt == FULL_M1) begin
                    clk_cnt_n = '0;
                    state_n   = IDLE;
                    if (rx_s) begin
                        code_n  = shadow;
                        par_n   = shadow_par;
                        valid_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    assign b1 = code[0];
    assign b2 = code[1];
    assign b3 = code[2];
    assign b4 = code[3];
    assign b5 = code[4];

endmodule

// File: tb/tb_serial_code_rx.sv
// Randomized bench for serial_code_rx: frames are driven bit by bit and compared
// against a frame-level model of the last good code, pulse counts and latency.
module tb_serial_code_rx;

    localparam int unsigned CPB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic b1, b2, b3, b4, b5, b_par, frame_valid, frame_err, busy;

    serial_code_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b_par(b_par),
        .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int last_valid_cyc = 0;
    int fall_cyc = 0;
    logic [4:0] exp_code = '0;
    logic       exp_par = 1'b0;
    int         exp_valid = 0;
    int         exp_err = 0;
    logic [5:0] prev_out = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts pulses and watches for output changes outside frame_valid
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_valid || frame_err) begin
                check("pulse_exclusive", 32'(frame_valid & frame_err), 32'd0);
                check("busy_at_pulse", 32'(busy), 32'd0);
            end
            if (frame_valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
            end
            if (frame_err) err_cnt++;
            if ({b1, b2, b3, b4, b5, b_par} != prev_out && !frame_valid)
                check("out_stable", 32'({b1, b2, b3, b4, b5, b_par}), 32'(prev_out));
        end
        prev_out = {b1, b2, b3, b4, b5, b_par};
    end

    task automatic wait_bit();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_code"}, 32'({b1, b2, b3, b4, b5}), 32'(exp_code));
        check({tag, "_par"}, 32'(b_par), 32'(exp_par));
        check({tag, "_nvalid"}, 32'(valid_cnt), 32'(exp_valid));
        check({tag, "_nerr"}, 32'(err_cnt), 32'(exp_err));
    endtask

    // code is written b1..b5 from MSB to LSB
    task automatic send_frame(input logic [4:0] code, input logic par, input logic stop);
        int lat;
        fall_cyc = cyc;
        rx = 1'b0;
        wait_bit();
        check("busy_mid_frame", 32'(busy), 32'd1);
        for (int i = 4; i >= 0; i--) begin
            rx = code[i];
            wait_bit();
        end
        rx = par;
        wait_bit();
        rx = stop;
        wait_bit();
        if (stop) begin
            exp_code = code;
            exp_par  = par;
            exp_valid++;
            lat = last_valid_cyc - fall_cyc;
            check("latency_in_window", 32'(lat >= 121 && lat <= 125), 32'd1);
        end else begin
            exp_err++;
        end
        check_outputs("frame");
    endtask

    initial begin
        int t1;
        logic [4:0] c;
        logic       p, s;
        int         gap;
        logic       prev_bad;

        // Reset and long idle line
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(20 * CPB);
        check("reset_busy", 32'(busy), 32'd0);
        check_outputs("reset");

        // Directed frame 10110 / parity 0
        send_frame(5'b10110, 1'b0, 1'b1);
        check("latency_exact_plus_sync", 32'(last_valid_cyc - fall_cyc), 32'd123);
        idle(CPB);

        // Short low glitch must be rejected in START
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle(3 * CPB);
        check("glitch_busy", 32'(busy), 32'd0);
        check_outputs("glitch");

        // Good frame followed by a framing error
        send_frame(5'b01001, 1'b1, 1'b1);
        idle(CPB);
        send_frame(5'b11111, 1'b0, 1'b0);
        idle(CPB);

        // Back-to-back frames, no idle gap
        send_frame(5'b00011, 1'b1, 1'b1);
        t1 = last_valid_cyc;
        send_frame(5'b10000, 1'b0, 1'b1);
        check("b2b_spacing", 32'(last_valid_cyc - t1), 32'(8 * CPB));
        idle(CPB);

        // Reset asserted during DATA bit 3
        rx = 1'b0; wait_bit();
        rx = 1'b1; wait_bit();
        rx = 1'b0; wait_bit();
        rx = 1'b1;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_code", 32'({b1, b2, b3, b4, b5, b_par}), 32'd0);
        rst_n = 1'b1;
        exp_code = '0;
        exp_par  = 1'b0;
        idle(4 * CPB);
        check("postreset_busy", 32'(busy), 32'd0);
        check_outputs("postreset");
        send_frame(5'b11010, 1'b1, 1'b1);
        idle(CPB);

        // Randomized frames with random stop bits and gaps
        prev_bad = 1'b0;
        for (int n = 0; n < 24; n++) begin
            c   = 5'($urandom);
            p   = 1'($urandom);
            s   = ($urandom_range(0, 3) != 0);
            gap = $urandom_range(0, 12);
            if (prev_bad && gap < 2) gap = 2;
            if (gap > 0) idle(gap);
            send_frame(c, p, s);
            prev_bad = !s;
        end
        idle(2 * CPB);
        check("final_busy", 32'(busy), 32'd0);
        check_outputs("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
